multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle ARM control unit.
- Sequences each instruction through fetch / decode / execute / memory / writeback states, one datapath action per cycle.
- Holds the architectural NZCV flag register internally.
- Talks to a shared instruction/data memory through a req/ready handshake with timeout.
- Sits between the instruction register/ALU and the multi-cycle datapath muxes.

Parameters:
- ALU_OP_W, 4: width of alu_op; the cmd field is zero-extended into it; must be >= 4.
- TIMEOUT_W, 4: width of the memory wait counter.
- MEM_TIMEOUT, 12: max cycles a memory state waits for mem_ready before aborting; must be < 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- opfunc  in  12  IR fields: [11:8] cond, [7:5] class, [4:1] cmd, [0] S/L
- alu_flags  in  4  NZCV produced by ALU this cycle
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a store (valid with mem_req)
- adr_src  out  1  0 = PC address, 1 = ALU result register
- ir_write  out  1  load IR from memory
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = Rn
- alu_src_b  out  2  00 = Rm, 01 = dp immediate, 10 = dt immediate, 11 = constant 4
- alu_op  out  ALU_OP_W  ALU command
- result_src  out  2  00 = ALU result register, 01 = memory data, 10 = PC (link)
- nzcv  out  4  flag register contents
- undef  out  1  one-cycle pulse on undefined class
- mem_fault  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset, asynchronous:
  - state = FETCH, nzcv = 0, wait counter = 0.
  - While rst is high, every output is 0 except nzcv, which shows its reset value 0.
- Outputs are Moore, decoded from state plus the stable opfunc. They default to 0 unless listed for a state.
- Class decode on opfunc[7:5]:
  - 00x: data processing (bit5 = immediate).
  - 01x: data transfer (bit5 = immediate, bit3 = up/add, bit0 = load).
  - 101: branch (bit4 = link).
  - 100 and 11x: undefined.
- Condition decode: EQ..LE per the standard ARM table, evaluated on the registered nzcv. 1110 = always; 1111 = never.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=11, alu_op=0100 (add).
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE:
  - Condition false → FETCH.
  - Undefined class → undef=1, FETCH.
  - Branch → BRANCH. Data processing → EXEC. Data transfer → MEMADR.
- EXEC:
  - Drives alu_src_a=1; alu_src_b=01 if bit5 else 00; alu_op=cmd.
  - If S=1, nzcv <= alu_flags at the end of this cycle.
  - If cmd[3:2]==10 (TST/TEQ/CMP/CMN) → FETCH; otherwise → ALUWB.
- ALUWB: reg_write=1, result_src=00 → FETCH.
- MEMADR:
  - Drives alu_src_a=1; alu_src_b=10 if bit5 else 11. Note 11 in this state means the register offset, via the datapath mux.
  - alu_op = 0100 if bit3 else 0010.
  - Load → MEMRD; store → MEMWR.
- MEMRD: mem_req=1, adr_src=1. On mem_ready → MEMWB.
- MEMWB: reg_write=1, result_src=01 → FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1. On mem_ready → FETCH.
- BRANCH:
  - Drives pc_write=1, pc_src=1.
  - If link: reg_write=1, result_src=10. The pre-update PC+4 is written to LR in the same cycle.
  - → FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR without mem_ready; cleared on state exit.
  - When it reaches MEM_TIMEOUT with mem_ready still low: pulse mem_fault for 1 cycle, drop mem_req, go to FETCH.
  - No IR or register write occurs on abort; the PC is unchanged.
  - mem_ready on the same cycle the counter hits MEM_TIMEOUT counts as success.
- mem_ready while mem_req is low is ignored.
- Flags change only in EXEC with S=1. A conditional instruction directly after a flag-setting one sees the new flags (decided 2+ cycles later).
- Reset mid-access drops mem_req immediately (asynchronous); no partial write is signalled.

Decomposition:
- Shared package arm_ctrl_pkg:
  - State enum.
  - Class codes, condition codes (COND_EQ..COND_NV).
  - ALU op constants ALU_ADD=0100, ALU_SUB=0010.
  - alu_src_b and result_src encodings.
- One sub-module: cond_check. Combinational; inputs cond[3:0] and nzcv; output pass. Reused by any later pipelined controller.

Test Plan:
- ADD r,r,imm with S=1, cond=1110, mem_ready high on the first FETCH cycle, alu_flags=0100 → state sequence FETCH, DECODE, EXEC, ALUWB, FETCH (4 cycles); reg_write high only in ALUWB; nzcv=0100 afterwards.
- CMP (cmd=1010, S=1), then BEQ (cond=0000, class=101) with alu_flags=0100 → no reg_write for CMP; BRANCH entered; pc_src=1 and pc_write=1 for 1 cycle. Repeat with alu_flags=0000 → DECODE returns to FETCH, no pc_write.
- LDR with bit3=1, bit5=1, mem_ready delayed 3 cycles in MEMRD → mem_req held 4 cycles with adr_src=1, alu_op=0100 in MEMADR; MEMWB asserts reg_write with result_src=01.
- STR with mem_ready never asserted, MEM_TIMEOUT=12 → mem_write and mem_req high for 12 cycles; mem_fault pulses once; next state FETCH; no reg_write.
- BL (class 101, bit4=1) → BRANCH asserts reg_write, result_src=10, pc_src=1 together. Class 110 → undef pulses 1 cycle in DECODE, then FETCH.
- Assert rst during MEMWR → mem_req and mem_write drop in the same cycle; after release state=FETCH and nzcv=0000. Cond=1111 instruction is never executed.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM multi-cycle control path.
// State enum, instruction class/condition codes, ALU and mux encodings.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH
    } state_e;

    typedef enum logic [1:0] {
        CL_DP,
        CL_DT,
        CL_BR,
        CL_UNDEF
    } class_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    localparam logic [1:0] SRCB_RM     = 2'b00;
    localparam logic [1:0] SRCB_DP_IMM = 2'b01;
    localparam logic [1:0] SRCB_DT_IMM = 2'b10;
    localparam logic [1:0] SRCB_FOUR   = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC  = 2'b10;

    // 00x dp, 01x dt, 101 branch, 100/11x undefined
    function automatic class_e decode_class(input logic [2:0] cls);
        class_e c;
        if (cls[2:1] == 2'b00)
            c = CL_DP;
        else if (cls[2:1] == 2'b01)
            c = CL_DT;
        else if (cls == 3'b101)
            c = CL_BR;
        else
            c = CL_UNDEF;
        return c;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator, purely combinational.
// Ports: cond[3:0], nzcv[3:0] in; pass out (1 = execute).
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle ARM control FSM with NZCV register and memory timeout.
// Ports: opfunc/alu_flags/mem_ready in; datapath mux, memory and pulse outputs.
module multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         opfunc,
    input  logic [3:0]          alu_flags,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          result_src,
    output logic [3:0]          nzcv,
    output logic                undef,
    output logic                mem_fault
);

    localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
        TIMEOUT_W'(MEM_TIMEOUT - 1);

    state_e               state;
    state_e               state_n;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 cond_pass;
    logic                 mem_state;
    logic                 timeout;
    class_e               cls;
    logic [3:0]           cmd;

    assign cls = decode_class(opfunc[7:5]);
    assign cmd = opfunc[4:1];

    cond_check u_cond (
        .cond (opfunc[11:8]),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    assign mem_state = (state == S_FETCH) ||
                       (state == S_MEMRD) ||
                       (state == S_MEMWR);

    // last permitted wait cycle; a late mem_ready here still wins
    assign timeout = mem_state && !mem_ready &&
                     (wait_cnt == WAIT_LAST);

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH:  if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                if (!cond_pass) begin
                    state_n = S_FETCH;
                end else begin
                    unique case (cls)
                        CL_DP:   state_n = S_EXEC;
                        CL_DT:   state_n = S_MEMADR;
                        CL_BR:   state_n = S_BRANCH;
                        default: state_n = S_FETCH;
                    endcase
                end
            end
            S_EXEC:
                state_n = (cmd[3:2] == 2'b10) ? S_FETCH : S_ALUWB;
            S_ALUWB:  state_n = S_FETCH;
            S_MEMADR:
                state_n = opfunc[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)
                    state_n = S_MEMWB;
                else if (timeout)
                    state_n = S_FETCH;
            end
            S_MEMWB:  state_n = S_FETCH;
            S_MEMWR:
                if (mem_ready || timeout) state_n = S_FETCH;
            S_BRANCH: state_n = S_FETCH;
            default:  state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            nzcv     <= 4'b0000;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == S_EXEC && opfunc[0])
                nzcv <= alu_flags;
            if (mem_state && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // reset gates every output so an in-flight access drops at once
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RM;
        alu_op     = '0;
        result_src = RES_ALU;
        undef      = 1'b0;
        mem_fault  = 1'b0;
        if (!rst) begin
            mem_fault = timeout;
            unique case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_OP_W'(ALU_ADD);
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:
                    undef = cond_pass && (cls == CL_UNDEF);
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = opfunc[5] ? SRCB_DP_IMM : SRCB_RM;
                    alu_op    = ALU_OP_W'(cmd);
                end
                S_ALUWB:
                    reg_write = 1'b1;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    // FOUR code selects the register offset here
                    alu_src_b = opfunc[5] ? SRCB_DT_IMM : SRCB_FOUR;
                    alu_op    = opfunc[3] ? ALU_OP_W'(ALU_ADD)
                                          : ALU_OP_W'(ALU_SUB);
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_BRANCH: begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                    if (opfunc[4]) begin
                        reg_write  = 1'b1;
                        result_src = RES_PC;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instruction-level model
// emits per-cycle expected outputs; a negedge monitor compares them.
module tb_multicycle_controller;

    localparam int MEM_TIMEOUT = 12;

    logic        clk;
    logic        rst;
    logic [11:0] opfunc;
    logic [3:0]  alu_flags;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write;
    logic        pc_write, pc_src, reg_write, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  result_src;
    logic [3:0]  nzcv;
    logic        undef, mem_fault;

    multicycle_controller #(
        .ALU_OP_W    (4),
        .TIMEOUT_W   (4),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opfunc     (opfunc),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .nzcv       (nzcv),
        .undef      (undef),
        .mem_fault  (mem_fault)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] result_src;
        logic [3:0] nzcv;
        logic       undef;
        logic       mem_fault;
    } vec_t;

    vec_t       act;
    vec_t       exp_q[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    logic [3:0] m_nzcv;

    assign act = {mem_req, mem_write, adr_src, ir_write,
                  pc_write, pc_src, reg_write, alu_src_a,
                  alu_src_b, alu_op, result_src, nzcv,
                  undef, mem_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        vec_t e;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act === e)
                passes++;
            else
                $display("FAIL outputs cycle %0d actual=%h required=%h",
                         cyc, act, e);
        end
    end

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // ARM condition table on the architectural flags
    function automatic bit cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
        bit n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vec_t idle_v();
        vec_t e;
        e = '0;
        e.nzcv = m_nzcv;
        return e;
    endfunction

    function automatic vec_t fetch_v(input bit done);
        vec_t e;
        e = idle_v();
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'b11;
        e.alu_op    = 4'b0100;
        e.ir_write  = done;
        e.pc_write  = done;
        return e;
    endfunction

    task automatic step(input vec_t e, input logic rdy);
        mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // w waiting cycles, then ready; w >= MEM_TIMEOUT aborts
    task automatic mem_access(input vec_t wait_v, input vec_t done_v,
                              input int w, output bit ok);
        vec_t t;
        ok = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (i == w) begin
                step(done_v, 1'b1);
                ok = 1'b1;
                return;
            end
            t = wait_v;
            if (i == MEM_TIMEOUT - 1)
                t.mem_fault = 1'b1;
            step(t, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [11:0] op,
                             input logic [3:0] fl,
                             input int fw, input int mw);
        vec_t e;
        bit   ok;
        bit   pass;
        bit   bad;
        logic [2:0] cl;
        alu_flags = 4'($urandom);
        mem_access(fetch_v(1'b0), fetch_v(1'b1), fw, ok);
        if (!ok)
            return;
        opfunc = op;
        cl   = op[7:5];
        pass = cond_ok(op[11:8], m_nzcv);
        bad  = (cl == 3'b100) || (cl[2:1] == 2'b11);
        e = idle_v();
        e.undef = pass && bad;
        step(e, rnd());
        if (!pass || bad)
            return;
        if (cl[2:1] == 2'b00) begin
            e = idle_v();
            e.alu_src_a = 1'b1;
            e.alu_src_b = op[5] ? 2'b01 : 2'b00;
            e.alu_op    = op[4:1];
            alu_flags   = fl;
            step(e, rnd());
            if (op[0])
                m_nzcv = fl;
            if (op[4:3] != 2'b10) begin
                e = idle_v();
                e.reg_write = 1'b1;
                step(e, rnd());
            end
        end else if (cl[2:1] == 2'b01) begin
            e = idle_v();
            e.alu_src_a = 1'b1;
            e.alu_src_b = op[5] ? 2'b10 : 2'b11;
            e.alu_op    = op[3] ? 4'b0100 : 4'b0010;
            step(e, rnd());
            e = idle_v();
            e.mem_req   = 1'b1;
            e.adr_src   = 1'b1;
            e.mem_write = !op[0];
            mem_access(e, e, mw, ok);
            if (ok && op[0]) begin
                e = idle_v();
                e.reg_write  = 1'b1;
                e.result_src = 2'b01;
                step(e, rnd());
            end
        end else begin
            e = idle_v();
            e.pc_write = 1'b1;
            e.pc_src   = 1'b1;
            if (op[4]) begin
                e.reg_write  = 1'b1;
                e.result_src = 2'b10;
            end
            step(e, rnd());
        end
    endtask

    task automatic reset_in_memwr();
        vec_t e;
        bit   ok;
        mem_access(fetch_v(1'b0), fetch_v(1'b1), 0, ok);
        opfunc = {4'hE, 3'b011, 4'b0100, 1'b0};
        step(idle_v(), rnd());
        e = idle_v();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        e.alu_op    = 4'b0100;
        step(e, rnd());
        e = idle_v();
        e.mem_req   = 1'b1;
        e.mem_write = 1'b1;
        e.adr_src   = 1'b1;
        step(e, 1'b0);
        step(e, 1'b0);
        rst    = 1'b1;
        m_nzcv = 4'b0000;
        step('0, rnd());
        step('0, rnd());
        rst = 1'b0;
    endtask

    logic [11:0] r_op;
    int          r_fw;
    int          r_mw;

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opfunc    = '0;
        alu_flags = '0;
        m_nzcv    = 4'b0000;
        @(posedge clk);
        #1;
        step('0, 1'b0);
        step('0, 1'b1);
        rst = 1'b0;

        run_instr({4'hE, 3'b001, 4'b0100, 1'b1}, 4'b0100, 0, 0);
        run_instr({4'hE, 3'b000, 4'b1010, 1'b1}, 4'b0100, 0, 0);
        run_instr({4'h0, 3'b101, 4'b0000, 1'b0}, 4'b0000, 0, 0);
        run_instr({4'hE, 3'b000, 4'b1010, 1'b1}, 4'b0000, 1, 0);
        run_instr({4'h0, 3'b101, 4'b0000, 1'b0}, 4'b0000, 0, 0);
        run_instr({4'hE, 3'b011, 4'b0100, 1'b1}, 4'b0000, 0, 3);
        run_instr({4'hE, 3'b011, 4'b0100, 1'b0}, 4'b0000, 0,
                  MEM_TIMEOUT);
        run_instr({4'hE, 3'b101, 4'b1000, 1'b0}, 4'b0000, 0, 0);
        run_instr({4'hE, 3'b110, 4'b0000, 1'b0}, 4'b0000, 0, 0);
        run_instr({4'hE, 3'b000, 4'b0100, 1'b1}, 4'b1010, 2, 0);
        reset_in_memwr();
        run_instr({4'hE, 3'b001, 4'b1101, 1'b1}, 4'b0011, 0, 0);
        run_instr({4'hF, 3'b000, 4'b0100, 1'b1}, 4'b1100, 0, 0);
        run_instr({4'hE, 3'b000, 4'b0100, 1'b0}, 4'b1111,
                  MEM_TIMEOUT - 1, 0);
        run_instr({4'hE, 3'b000, 4'b0100, 1'b1}, 4'b1111,
                  MEM_TIMEOUT, 0);
        run_instr({4'hE, 3'b010, 4'b0000, 1'b1}, 4'b0000, 0,
                  MEM_TIMEOUT - 1);
        run_instr({4'hE, 3'b010, 4'b0000, 1'b0}, 4'b0000, 0, 0);

        for (int k = 0; k < 250; k++) begin
            r_op = 12'($urandom);
            if ($urandom_range(0, 2) == 0)
                r_op[11:8] = 4'hE;
            r_fw = ($urandom_range(0, 11) == 0) ? MEM_TIMEOUT
                                                : $urandom_range(0, 3);
            r_mw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT
                                               : $urandom_range(0, 4);
            run_instr(r_op, 4'($urandom), r_fw, r_mw);
        end

        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL queue_drain actual=%0d required=0",
                     exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
